mem_responder: RTL and testbench
================================

# mem_responder

Word-organised data memory that answers the CPU-side memory port through a request/acknowledge handshake with a programmable wait-state count. It is the responder end of the processor's memory interface, replacing the fixed-latency memory with a block the control unit must wait on. It latches one request, holds it for WAIT_CYCLES, performs the read or write, and pulses an acknowledge carrying read data and an error flag.

## Interface
- ADDR_WIDTH, 8: byte-address bits decoded; storage is 2^(ADDR_WIDTH-2) 32-bit words.
- WAIT_CYCLES, 2: wait states between accept and response; legal range 0..15.
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid from the initiator.
- wr  in  1  1 = write, 0 = read; sampled with req.
- address  in  32  byte address; sampled with req.
- datain  in  32  write data; sampled with req.
- ready  out  1  responder can accept a request this cycle.
- ack  out  1  one-cycle pulse completing the transaction.
- dataout  out  32  read data; valid when ack=1, held until the next ack.
- err  out  1  transaction faulted; valid only with ack.

## Operation
- States: IDLE, WAIT, RESP.
  - IDLE: ready=1.
  - WAIT and RESP: ready=0.
- Accept: in IDLE with req=1, latch address, wr and datain, and load the 4-bit wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - Counter decrements each cycle.
  - Move to RESP in the cycle the counter is 1.
  - Inputs are ignored; the latched copies are used.
- RESP:
  - Drive ack=1 for exactly one cycle, then return to IDLE.
- Error: err=1 when address[1:0]!=0 or any of address[31:ADDR_WIDTH] is nonzero.
  - On error, no write occurs and dataout is 0.
- Write:
  - Word at index address[ADDR_WIDTH-1:2] is updated at the clock edge ending RESP.
  - On a write, dataout is set to the written value.
- Read:
  - dataout is loaded at the clock edge entering RESP, so it is stable during ack.
- req while ready=0 is ignored and not queued. The initiator must hold req until it sees ready=1.
- Storage contents are not cleared by reset; they are undefined until written.

## Timing
- Reset values (cycle after reset high): state IDLE, ready=1, ack=0, err=0, dataout=0, counter=0.
- Latency:
  - Request accepted at edge T; ack is high during cycle T+WAIT_CYCLES+1.
  - With WAIT_CYCLES=0, ack is high in the cycle immediately after acceptance.
- Throughput: one transaction per WAIT_CYCLES+2 cycles.
  - req held high through ack is accepted again in the first IDLE cycle after ack.
- Read-after-write: a read accepted after a write's ack returns the new data.
- Reset mid-operation:
  - Returns to IDLE next cycle, with ack=0 and err=0.
  - A pending write is discarded; the memory word is unchanged.
- ack and ready are never high in the same cycle.

## Test plan
- Reset, then idle 3 cycles -> ready=1, ack=0, err=0, dataout=0 throughout.
- Write 0xDEADBEEF to 0x10 with WAIT_CYCLES=2, then read 0x10:
  - Write ack arrives in the 3rd cycle after accept.
  - Read returns dataout=0xDEADBEEF, err=0.
- Read 0x12 (misaligned), then write 0x100 (out of range for ADDR_WIDTH=8):
  - Each returns ack with err=1 and dataout=0.
  - A later read of 0x00 is unchanged.
- Hold req=1 continuously for 4 reads to 0x0, 0x4, 0x8, 0xC:
  - One ack every 4 cycles.
  - Address changes presented while busy have no effect.
- Accept a write of 0x12345678 to 0x20, then assert reset during WAIT:
  - Ack never appears.
  - A read of 0x20 returns the prior value 0xCAFEF00D.
- WAIT_CYCLES=0 instance, write then read 0x3C:
  - Ack one cycle after each accept.
  - Read data equals the written data.

Source files
------------

// File: rtl/mem_responder.sv
// Word-organised data memory answering a req/ready/ack port after WAIT_CYCLES wait states.
// One request is latched at a time; the response carries read data and an error flag.
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] address,
    input  logic [31:0] datain,
    output logic        ready,
    output logic        ack,
    output logic [31:0] dataout,
    output logic        err,
    output logic [1:0]  state_dbg
);

    // Handshake: a request transfers on a rising edge where req=1 and ready=1;
    // the initiator holds req/wr/address/datain until then. ack pulses once per transfer.

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, next_state;

    logic [3:0]  cnt;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic        cur_wr;
    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic        cur_err;
    logic        enter_resp;
    logic [ADDR_WIDTH-3:0] cur_idx;
    logic [ADDR_WIDTH-3:0] idx_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        ack        = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
            WAIT: begin
                if (cnt == 4'd1) next_state = RESP;
            end
            RESP: begin
                ack        = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign state_dbg = state;
    assign err       = ack & err_q;

    // With zero wait states the response is formed on the accept edge itself,
    // so the live inputs stand in for the latched copies while in IDLE.
    assign cur_wr     = (state == IDLE) ? wr      : wr_q;
    assign cur_addr   = (state == IDLE) ? address : addr_q;
    assign cur_data   = (state == IDLE) ? datain  : data_q;
    assign cur_err    = (cur_addr[1:0] != 2'b00) || ((cur_addr >> ADDR_WIDTH) != 32'd0);
    assign cur_idx    = cur_addr[ADDR_WIDTH-1:2];
    assign idx_q      = addr_q[ADDR_WIDTH-1:2];
    assign enter_resp = (next_state == RESP) && (state != RESP);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
            dataout <= 32'd0;
        end else begin
            if (state == IDLE && req) begin
                cnt    <= WAIT_LOAD;
                wr_q   <= wr;
                addr_q <= address;
                data_q <= datain;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q <= cur_err;
                if (cur_err)     dataout <= 32'd0;
                else if (cur_wr) dataout <= cur_data;
                else             dataout <= mem[cur_idx];
            end
        end
    end

    // Storage is deliberately not reset; a reset during RESP cancels the write.
    always_ff @(posedge clock) begin
        if (!reset && state == RESP && wr_q && !err_q) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance driven from a vector table and
// hand sequences, plus a WAIT_CYCLES=0 instance; ack responses are scored from a queue.
module tb_mem_responder;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic req0, wr0, ready0, ack0, err0;
    logic [31:0] address0, datain0, dataout0;
    logic [1:0] state0;
    logic req1, wr1, ready1, ack1, err1;
    logic [31:0] address1, datain1, dataout1;
    logic [1:0] state1;

    mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut0 (
        .clock(clock), .reset(reset), .req(req0), .wr(wr0), .address(address0),
        .datain(datain0), .ready(ready0), .ack(ack0), .dataout(dataout0),
        .err(err0), .state_dbg(state0)
    );

    mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut1 (
        .clock(clock), .reset(reset), .req(req1), .wr(wr1), .address(address1),
        .datain(datain1), .ready(ready1), .ack(ack1), .dataout(dataout1),
        .err(err1), .state_dbg(state1)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp1_q[$];
    logic [32:0] e0, e1;
    vec_t vecs[14];
    logic [31:0] hold_addr[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboards: every ack pops one expected {err, data} record.
    always @(negedge clock) begin
        if (ack0 === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("dut0_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e0 = exp_q.pop_front();
                check("dut0_dataout", dataout0, e0[31:0]);
                check("dut0_err", 32'(err0), 32'(e0[32]));
                check("dut0_ready_during_ack", 32'(ready0), 32'd0);
            end
        end
        if (ack1 === 1'b1) begin
            if (exp1_q.size() == 0) begin
                check("dut1_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e1 = exp1_q.pop_front();
                check("dut1_dataout", dataout1, e1[31:0]);
                check("dut1_err", 32'(err1), 32'(e1[32]));
                check("dut1_ready_during_ack", 32'(ready1), 32'd0);
            end
        end
    end

    task automatic txn0(input vec_t v, input int exp_lat);
        int n;
        @(negedge clock);
        req0 = 1'b1; wr0 = v.wr; address0 = v.addr; datain0 = v.data;
        n = 0;
        while (ready0 !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("dut0_ready_timeout", 32'(ready0), 32'd1);
        exp_q.push_back({v.exp_err, v.exp_data});
        @(posedge clock);
        #1;
        req0 = 1'b0; wr0 = 1'($urandom_range(0, 1));
        address0 = 32'($urandom_range(0, 255)); datain0 = $urandom;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (ack0 !== 1'b1 && n < 50);
        check("dut0_ack_latency", 32'(n), 32'(exp_lat));
    endtask

    task automatic txn1(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_err);
        int n;
        @(negedge clock);
        req1 = 1'b1; wr1 = w; address1 = a; datain1 = d;
        check("dut1_ready", 32'(ready1), 32'd1);
        exp1_q.push_back({exp_err, exp_data});
        @(posedge clock);
        #1;
        req1 = 1'b0; address1 = 32'($urandom_range(0, 255)); datain1 = $urandom;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (ack1 !== 1'b1 && n < 20);
        check("dut1_ack_latency", 32'(n), 32'd1);
    endtask

    initial begin
        int acks, cyc, last;
        bit saw_ack;

        vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h00, 32'h11112222, 32'h11112222, 1'b0};
        vecs[3]  = '{1'b0, 32'h12, 32'h0,        32'h0,        1'b1};
        vecs[4]  = '{1'b1, 32'h100, 32'h55555555, 32'h0,       1'b1};
        vecs[5]  = '{1'b0, 32'h00, 32'h0,        32'h11112222, 1'b0};
        vecs[6]  = '{1'b1, 32'h20, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vecs[7]  = '{1'b1, 32'h21, 32'h99999999, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'h80000020, 32'h77777777, 32'h0,  1'b1};
        vecs[9]  = '{1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b1, 32'h04, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        vecs[11] = '{1'b1, 32'h08, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0};
        vecs[12] = '{1'b1, 32'h0C, 32'h01234567, 32'h01234567, 1'b0};
        vecs[13] = '{1'b1, 32'hFC, 32'h0BADF00D, 32'h0BADF00D, 1'b0};
        hold_addr[0] = 32'h0; hold_addr[1] = 32'h4; hold_addr[2] = 32'h8; hold_addr[3] = 32'hC;

        reset = 1'b1;
        req0 = 1'b0; wr0 = 1'b0; address0 = 32'd0; datain0 = 32'd0;
        req1 = 1'b0; wr1 = 1'b0; address1 = 32'd0; datain1 = 32'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_ready", 32'(ready0), 32'd1);
            check("reset_ack", 32'(ack0), 32'd0);
            check("reset_err", 32'(err0), 32'd0);
            check("reset_dataout", dataout0, 32'd0);
            check("reset_state", 32'(state0), 32'd0);
            check("reset_dut1_ready", 32'(ready1), 32'd1);
            check("reset_dut1_dataout", dataout1, 32'd0);
        end

        for (int i = 0; i < 14; i++) txn0(vecs[i], 3);
        txn0('{1'b0, 32'hFC, 32'h0, 32'h0BADF00D, 1'b0}, 3);

        // req held high across four reads; busy-time address changes must be ignored.
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, vecs[i == 0 ? 2 : 9 + i].exp_data});
        @(negedge clock);
        wr0 = 1'b0; req0 = 1'b1; address0 = hold_addr[0];
        acks = 0; cyc = 0; last = 0;
        while (acks < 4 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (ack0 === 1'b1) begin
                if (acks == 0) check("hold_first_ack", 32'(cyc), 32'd3);
                else           check("hold_ack_spacing", 32'(cyc - last), 32'd4);
                last = cyc;
                acks++;
                if (acks < 4) address0 = hold_addr[acks];
                else          req0 = 1'b0;
            end else if (ready0 === 1'b0) begin
                address0 = 32'($urandom_range(0, 255)) & 32'hFC;
            end
        end
        req0 = 1'b0;
        check("hold_ack_count", 32'(acks), 32'd4);

        // Reset during WAIT cancels a pending write.
        @(negedge clock);
        req0 = 1'b1; wr0 = 1'b1; address0 = 32'h20; datain0 = 32'h12345678;
        check("rst_mid_ready", 32'(ready0), 32'd1);
        @(posedge clock);
        #1;
        req0 = 1'b0; wr0 = 1'b0;
        @(negedge clock);
        check("rst_mid_in_wait", 32'(state0), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_state", 32'(state0), 32'd0);
        check("rst_mid_ready_after", 32'(ready0), 32'd1);
        check("rst_mid_ack", 32'(ack0), 32'd0);
        check("rst_mid_err", 32'(err0), 32'd0);
        reset = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (ack0 === 1'b1) saw_ack = 1'b1;
        end
        check("rst_mid_no_ack", 32'(saw_ack), 32'd0);
        txn0('{1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0}, 3);

        // Zero-wait-state instance.
        txn1(1'b1, 32'h3C, 32'h600DCAFE, 32'h600DCAFE, 1'b0);
        txn1(1'b0, 32'h3C, 32'h0, 32'h600DCAFE, 1'b0);
        txn1(1'b0, 32'h3E, 32'h0, 32'h0, 1'b1);
        txn1(1'b0, 32'h3C, 32'h0, 32'h600DCAFE, 1'b0);

        repeat (3) @(negedge clock);
        check("dut0_queue_drained", 32'(exp_q.size()), 32'd0);
        check("dut1_queue_drained", 32'(exp1_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
